// File: rtl/wb_trace_checker.sv
// Writeback-trace checker: buffers CPU register-file writes and compares them in order against a golden trace.
// Latency: an event captured at edge N can be compared at edge N+1; counters/verdict are visible the cycle after the compare.
// Backpressure: never stalls the CPU; a push into a full FIFO with no pop is dropped and forces FAIL. Golden stream is paced by ref_ready.
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   debug_wb_pc/rf_wen/rf_addr/rf_wdata   CPU commit stream (an event is wen with addr != 0)
//   ref_valid/ref_ready              golden stream handshake; ref_pc/ref_addr/ref_wdata/ref_last golden fields
//   pass, fail, overflow             sticky verdict flags
//   err_count (saturating), match_count   compare statistics
//   fail_pc/fail_addr/fail_wdata     CPU-side fields of the first mismatching entry
//
// Optional feature macro: TRACE_STOP_ON_ERR_EN -- when defined, the first mismatch ends the run in FAIL
// at that compare and nothing further is consumed. Undefined, mismatches are counted and the verdict waits for ref_last.
module wb_trace_checker #(
    parameter int DEPTH = 8,
    parameter int ERRW  = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      debug_wb_pc,
    input  logic             debug_wb_rf_wen,
    input  logic [4:0]       debug_wb_rf_addr,
    input  logic [31:0]      debug_wb_rf_wdata,
    input  logic             ref_valid,
    output logic             ref_ready,
    input  logic [31:0]      ref_pc,
    input  logic [4:0]       ref_addr,
    input  logic [31:0]      ref_wdata,
    input  logic             ref_last,
    output logic             pass,
    output logic             fail,
    output logic             overflow,
    output logic [ERRW-1:0]  err_count,
    output logic [31:0]      match_count,
    output logic [31:0]      fail_pc,
    output logic [4:0]       fail_addr,
    output logic [31:0]      fail_wdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]     PTR_INC = {{AW{1'b0}}, 1'b1};
    localparam logic [ERRW-1:0] ERR_INC = {{(ERRW-1){1'b0}}, 1'b1};
    localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_FAIL = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } wb_ent_t;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    wb_ent_t         r_mem [DEPTH];
    logic            r_overflow;
    logic [ERRW-1:0] r_err_count;
    logic [31:0]     r_match_count;
    wb_ent_t         r_fail;

    wb_ent_t w_ev;
    wb_ent_t w_ref;
    wb_ent_t w_head;
    logic    w_run;
    logic    w_empty;
    logic    w_full;
    logic    w_pop;
    logic    w_push_req;
    logic    w_push;
    logic    w_ovf_evt;
    logic    w_mismatch;
    logic    w_err_seen;
    logic    w_stop_err;

    assign w_ev   = {debug_wb_pc, debug_wb_rf_addr, debug_wb_rf_wdata};
    assign w_ref  = {ref_pc, ref_addr, ref_wdata};
    assign w_head = r_mem[r_rptr[AW-1:0]];

    assign w_run   = (r_state == ST_RUN);
    // Extra pointer MSB distinguishes full from empty when the index bits coincide.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // Ready depends only on state and occupancy, never on ref_valid.
    assign ref_ready = w_run && !w_empty;
    assign w_pop     = ref_valid && ref_ready;

    // x0 writes are architecturally invisible and are not traced.
    assign w_push_req = w_run && debug_wb_rf_wen && (debug_wb_rf_addr != 5'd0);
    // A simultaneous pop frees a slot, so a full FIFO can still accept the push.
    assign w_ovf_evt  = w_push_req && w_full && !w_pop;
    assign w_push     = w_push_req && !w_ovf_evt;

    assign w_mismatch = w_pop && (w_head != w_ref);
    // err_count saturates rather than wrapping, so nonzero means an error has been seen.
    assign w_err_seen = (r_err_count != '0);

`ifdef TRACE_STOP_ON_ERR_EN
    assign w_stop_err = w_mismatch;
`else
    assign w_stop_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (w_ovf_evt) begin
            w_state_nxt = ST_FAIL;
        end else if (w_pop) begin
            if (ref_last) begin
                w_state_nxt = (w_mismatch || w_err_seen) ? ST_FAIL : ST_PASS;
            end
            if (w_stop_err) begin
                w_state_nxt = ST_FAIL;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_RUN;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_overflow    <= 1'b0;
            r_err_count   <= '0;
            r_match_count <= '0;
            r_fail        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + PTR_INC;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_INC;
            end
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
            if (w_pop && !w_mismatch) begin
                r_match_count <= r_match_count + 32'd1;
            end
            if (w_mismatch) begin
                if (r_err_count != ERR_MAX) begin
                    r_err_count <= r_err_count + ERR_INC;
                end
                if (!w_err_seen) begin
                    r_fail <= w_head;
                end
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_ev;
        end
    end

    assign pass        = (r_state == ST_PASS);
    assign fail        = (r_state == ST_FAIL);
    assign overflow    = r_overflow;
    assign err_count   = r_err_count;
    assign match_count = r_match_count;
    assign fail_pc     = r_fail.pc;
    assign fail_addr   = r_fail.addr;
    assign fail_wdata  = r_fail.wdata;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Testbench for wb_trace_checker: scenario tasks driving the CPU and golden streams.
// Latency: inputs applied after a rising edge, outputs sampled 1 time unit after the next edge.
// Backpressure: golden entries advance only on a modelled handshake; CPU events are never held.
module tb_wb_trace_checker;

    localparam int DEPTH  = 8;
    localparam int ERRW   = 16;
    localparam int M_RUN  = 0;
    localparam int M_PASS = 1;
    localparam int M_FAIL = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } ent_t;

    logic            clk = 1'b0;
    logic            resetn;
    logic [31:0]     debug_wb_pc;
    logic            debug_wb_rf_wen;
    logic [4:0]      debug_wb_rf_addr;
    logic [31:0]     debug_wb_rf_wdata;
    logic            ref_valid;
    logic            ref_ready;
    logic [31:0]     ref_pc;
    logic [4:0]      ref_addr;
    logic [31:0]     ref_wdata;
    logic            ref_last;
    logic            pass;
    logic            fail;
    logic            overflow;
    logic [ERRW-1:0] err_count;
    logic [31:0]     match_count;
    logic [31:0]     fail_pc;
    logic [4:0]      fail_addr;
    logic [31:0]     fail_wdata;

    always #5 clk = ~clk;

    wb_trace_checker #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_addr  (debug_wb_rf_addr),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .ref_valid         (ref_valid),
        .ref_ready         (ref_ready),
        .ref_pc            (ref_pc),
        .ref_addr          (ref_addr),
        .ref_wdata         (ref_wdata),
        .ref_last          (ref_last),
        .pass              (pass),
        .fail              (fail),
        .overflow          (overflow),
        .err_count         (err_count),
        .match_count       (match_count),
        .fail_pc           (fail_pc),
        .fail_addr         (fail_addr),
        .fail_wdata        (fail_wdata)
    );

    int total = 0;
    int bad   = 0;

    // Scoreboard: CPU events expected to be buffered, popped on each modelled compare.
    ent_t sb_q[$];
    int   m_state;
    int   m_match;
    int   m_err;
    bit   m_ovf;
    ent_t m_fail;

    ent_t tr_ev[$];
    ent_t tr_gold[$];

    function automatic bit m_ready();
        return (m_state == M_RUN) && (sb_q.size() != 0);
    endfunction

    task automatic set_idle();
        debug_wb_rf_wen   = 1'b0;
        debug_wb_pc       = '0;
        debug_wb_rf_addr  = '0;
        debug_wb_rf_wdata = '0;
        ref_valid         = 1'b0;
        ref_pc            = '0;
        ref_addr          = '0;
        ref_wdata         = '0;
        ref_last          = 1'b0;
    endtask

    task automatic model_clear();
        sb_q.delete();
        m_state = M_RUN;
        m_match = 0;
        m_err   = 0;
        m_ovf   = 1'b0;
        m_fail  = '0;
    endtask

    task automatic do_reset();
        set_idle();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    // One clock: apply inputs, advance the scoreboard model, step past the edge.
    task automatic cyc(input bit wen, input ent_t ev, input bit rv, input ent_t rf,
                       input bit last, output bit fired);
        bit   full_b;
        bit   ev_ok;
        ent_t h;
        debug_wb_rf_wen   = wen;
        debug_wb_pc       = ev.pc;
        debug_wb_rf_addr  = ev.addr;
        debug_wb_rf_wdata = ev.wdata;
        ref_valid         = rv;
        ref_pc            = rf.pc;
        ref_addr          = rf.addr;
        ref_wdata         = rf.wdata;
        ref_last          = last;
        fired  = rv && m_ready();
        ev_ok  = (m_state == M_RUN) && wen && (ev.addr != 5'd0);
        full_b = (sb_q.size() == DEPTH);
        if (fired) begin
            h = sb_q.pop_front();
            if (h != rf) begin
                if (m_err == 0) m_fail = h;
                m_err++;
`ifdef TRACE_STOP_ON_ERR_EN
                m_state = M_FAIL;
`endif
            end else begin
                m_match++;
            end
            if (last && m_state == M_RUN) m_state = (m_err == 0) ? M_PASS : M_FAIL;
        end
        if (ev_ok) begin
            if (full_b && !fired) begin
                m_ovf   = 1'b1;
                m_state = M_FAIL;
            end else begin
                sb_q.push_back(ev);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drives tr_ev one per cycle while offering tr_gold with ref_valid high; last golden entry flagged.
    task automatic run_trace(input int budget, output int n_cmp);
        bit   f;
        ent_t e;
        ent_t r;
        n_cmp = 0;
        for (int c = 0; c < budget; c++) begin
            if (n_cmp >= tr_gold.size() || m_state != M_RUN) break;
            if (c < tr_ev.size()) e = tr_ev[c];
            else e = '0;
            r = tr_gold[n_cmp];
            cyc(c < tr_ev.size(), e, 1'b1, r, n_cmp == tr_gold.size() - 1, f);
            if (f) n_cmp++;
        end
        set_idle();
    endtask

    task automatic build_five();
        ent_t e;
        tr_ev.delete();
        for (int i = 0; i < 5; i++) begin
            e.pc    = 32'(4 * i);
            e.addr  = 5'(i + 1);
            e.wdata = 32'(i + 1);
            tr_ev.push_back(e);
        end
        tr_gold = tr_ev;
    endtask

    task automatic test_reset();
        set_idle();
        resetn = 1'b0;
        #12;
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass: got %b want 0", pass); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail: got %b want 0", fail); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        total++; if (ref_ready !== 1'b0) begin bad++; $display("FAIL reset_ref_ready: got %b want 0", ref_ready); end
        total++; if (err_count !== '0) begin bad++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        total++; if (match_count !== 32'd0) begin bad++; $display("FAIL reset_match_count: got %0d want 0", match_count); end
        total++; if ({fail_pc, fail_addr, fail_wdata} !== 69'd0) begin bad++; $display("FAIL reset_fail_fields: got %h/%h/%h want 0", fail_pc, fail_addr, fail_wdata); end
        do_reset();
    endtask

    task automatic test_pass_trace();
        int n;
        do_reset();
        build_five();
        run_trace(40, n);
        total++; if (n != 5) begin bad++; $display("FAIL pass_compares: got %0d want 5 (cycle budget expired)", n); end
        total++; if (match_count !== 32'd5) begin bad++; $display("FAIL pass_match_count: got %0d want 5", match_count); end
        total++; if (err_count !== '0) begin bad++; $display("FAIL pass_err_count: got %0d want 0", err_count); end
        total++; if (pass !== 1'b1 || fail !== 1'b0) begin bad++; $display("FAIL pass_verdict: got pass=%b fail=%b want 1/0", pass, fail); end
        total++; if (ref_ready !== 1'b0) begin bad++; $display("FAIL pass_ready_after: got %b want 0", ref_ready); end
    endtask

    task automatic test_addr0_bubbles();
        bit   f;
        ent_t e;
        ent_t z;
        do_reset();
        z = '0;
        for (int i = 0; i < 6; i++) begin
            e.pc    = 32'h80 + 32'(4 * i);
            e.addr  = (i % 2 == 0) ? 5'd0 : 5'(i + 3);
            e.wdata = 32'hA0 + 32'(i);
            // Even cycles: wen with x0; odd cycles: bubbles with a nonzero address but wen low.
            cyc(i % 2 == 0, e, 1'b1, z, 1'b0, f);
            total++; if (ref_ready !== 1'b0) begin bad++; $display("FAIL bubble_ready_%0d: got %b want 0", i, ref_ready); end
        end
        set_idle();
        total++; if (match_count !== 32'd0 || err_count !== '0) begin bad++; $display("FAIL bubble_counts: got match=%0d err=%0d want 0/0", match_count, err_count); end
    endtask

    task automatic test_mismatch();
        int n;
        do_reset();
        build_five();
        tr_ev[2].wdata   = 32'h8;
        tr_gold[2].wdata = 32'h7;
        run_trace(40, n);
        total++; if (fail !== 1'b1 || pass !== 1'b0) begin bad++; $display("FAIL mm_verdict: got pass=%b fail=%b want 0/1", pass, fail); end
        total++; if (err_count !== ERRW'(1)) begin bad++; $display("FAIL mm_err_count: got %0d want 1", err_count); end
        total++; if (fail_pc !== 32'h8 || fail_pc !== m_fail.pc) begin bad++; $display("FAIL mm_fail_pc: got %h want 8", fail_pc); end
        total++; if (fail_wdata !== 32'h8) begin bad++; $display("FAIL mm_fail_wdata: got %h want 8", fail_wdata); end
        total++; if (fail_addr !== 5'd3) begin bad++; $display("FAIL mm_fail_addr: got %0d want 3", fail_addr); end
`ifdef TRACE_STOP_ON_ERR_EN
        total++; if (match_count !== 32'd2) begin bad++; $display("FAIL mm_match_count: got %0d want 2", match_count); end
        total++; if (n != 3) begin bad++; $display("FAIL mm_compares: got %0d want 3", n); end
`else
        total++; if (match_count !== 32'd4) begin bad++; $display("FAIL mm_match_count: got %0d want 4", match_count); end
        total++; if (n != 5) begin bad++; $display("FAIL mm_compares: got %0d want 5 (cycle budget expired)", n); end
`endif
        total++; if (ref_ready !== 1'b0) begin bad++; $display("FAIL mm_ready_after: got %b want 0", ref_ready); end
    endtask

    task automatic test_overflow();
        bit   f;
        ent_t e;
        ent_t z;
        do_reset();
        z = '0;
        tr_ev.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            e.pc    = 32'h200 + 32'(4 * i);
            e.addr  = 5'((i % 31) + 1);
            e.wdata = $urandom;
            tr_ev.push_back(e);
            cyc(1'b1, e, 1'b0, z, 1'b0, f);
            if (i < DEPTH) begin
                total++; if (overflow !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL ovf_early_%0d: got ovf=%b fail=%b want 0/0", i, overflow, fail); end
            end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL ovf_fail: got %b want 1", fail); end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, z, 1'b1, tr_ev[i], 1'b0, f);
            total++; if (ref_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready_%0d: got %b want 0", i, ref_ready); end
        end
        set_idle();
        total++; if (match_count !== 32'd0 || err_count !== '0) begin bad++; $display("FAIL ovf_frozen: got match=%0d err=%0d want 0/0", match_count, err_count); end
    endtask

    task automatic test_back_to_back();
        bit   f;
        int   g;
        ent_t e;
        ent_t z;
        do_reset();
        z = '0;
        g = 0;
        tr_ev.delete();
        for (int i = 0; i < DEPTH + 20; i++) begin
            e.pc    = 32'h100 + 32'(4 * i);
            e.addr  = 5'((i % 31) + 1);
            e.wdata = $urandom;
            tr_ev.push_back(e);
        end
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, tr_ev[i], 1'b0, z, 1'b0, f);
        total++; if (ref_ready !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL b2b_full: got ready=%b ovf=%b want 1/0", ref_ready, overflow); end
        // Full FIFO: every cycle pushes one event and pops one entry.
        for (int i = DEPTH; i < DEPTH + 20; i++) begin
            cyc(1'b1, tr_ev[i], 1'b1, tr_ev[g], 1'b0, f);
            if (f) g++;
            total++; if (ref_ready !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL b2b_steady_%0d: got ready=%b ovf=%b want 1/0", i, ref_ready, overflow); end
        end
        total++; if (match_count !== 32'd20) begin bad++; $display("FAIL b2b_mid_match: got %0d want 20", match_count); end
        for (int c = 0; c < 20 && g < DEPTH + 20; c++) begin
            cyc(1'b0, z, 1'b1, tr_ev[g], 1'b0, f);
            if (f) g++;
        end
        set_idle();
        total++; if (g != DEPTH + 20) begin bad++; $display("FAIL b2b_drain: got %0d compares want %0d", g, DEPTH + 20); end
        total++; if (match_count !== 32'd28 || err_count !== '0) begin bad++; $display("FAIL b2b_counts: got match=%0d err=%0d want 28/0", match_count, err_count); end
        total++; if (ref_ready !== 1'b0 || fail !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL b2b_end: got ready=%b fail=%b ovf=%b want 0/0/0", ref_ready, fail, overflow); end
    endtask

    task automatic test_async_reset();
        bit   f;
        int   n;
        ent_t a;
        ent_t b;
        ent_t g;
        ent_t z;
        do_reset();
        z = '0;
        a = '{pc: 32'h40, addr: 5'd7, wdata: 32'h11};
        b = '{pc: 32'h44, addr: 5'd8, wdata: 32'h22};
        g = b;
        g.wdata = 32'h99;
        cyc(1'b1, a, 1'b0, z, 1'b0, f);
        cyc(1'b1, b, 1'b1, a, 1'b0, f);
        cyc(1'b0, z, 1'b1, g, 1'b0, f);
        set_idle();
        total++; if (match_count !== 32'd1 || err_count !== ERRW'(1) || fail_pc !== 32'h44) begin bad++; $display("FAIL ar_pre: got match=%0d err=%0d fpc=%h want 1/1/44", match_count, err_count, fail_pc); end
        #3 resetn = 1'b0;
        #1;
        total++; if (pass !== 1'b0 || fail !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL ar_flags: got pass=%b fail=%b ovf=%b want 0/0/0", pass, fail, overflow); end
        total++; if (match_count !== 32'd0 || err_count !== '0) begin bad++; $display("FAIL ar_counts: got match=%0d err=%0d want 0/0", match_count, err_count); end
        total++; if ({fail_pc, fail_addr, fail_wdata} !== 69'd0) begin bad++; $display("FAIL ar_fail_fields: got %h/%h/%h want 0", fail_pc, fail_addr, fail_wdata); end
        total++; if (ref_ready !== 1'b0) begin bad++; $display("FAIL ar_ready: got %b want 0", ref_ready); end
        @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        build_five();
        tr_ev   = tr_ev[0:2];
        tr_gold = tr_ev;
        run_trace(30, n);
        total++; if (n != 3) begin bad++; $display("FAIL ar_compares: got %0d want 3 (cycle budget expired)", n); end
        total++; if (pass !== 1'b1 || match_count !== 32'd3 || match_count !== 32'(m_match)) begin bad++; $display("FAIL ar_retrace: got pass=%b match=%0d want 1/3", pass, match_count); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_pass_trace();
        test_addr0_bubbles();
        test_mismatch();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Writeback-trace consumer for the pipelined CPU: it receives the CPU's `debug_wb_*` commit stream, buffers every register-file write in a small FIFO, and compares it in order against a golden trace supplied over a valid/ready stream. It reports pass/fail, match and error counts, and the first mismatch. It sits in the simulation/FPGA test top beside `cpu`, on the receiving end of the debug interface. It never stalls the CPU.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `ERRW`, 16: width of `err_count`; saturating.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  reset; one clock; asynchronous, active-low.
- `debug_wb_pc`  in  32  PC of the committing instruction.
- `debug_wb_rf_wen`  in  1  register-file write enable from the CPU.
- `debug_wb_rf_addr`  in  5  destination register.
- `debug_wb_rf_wdata`  in  32  write data.
- `ref_valid`  in  1  golden entry available.
- `ref_ready`  out  1  checker consumes the golden entry this cycle.
- `ref_pc` / `ref_addr` / `ref_wdata`  in  32/5/32  golden fields.
- `ref_last`  in  1  the golden entry is the final one.
- `pass`  out  1  sticky; trace completed with no errors.
- `fail`  out  1  sticky; a mismatch or overflow was detected.
- `overflow`  out  1  sticky; a CPU event was dropped.
- `err_count`  out  ERRW  count of mismatches.
- `match_count`  out  32  count of matched entries.
- `fail_pc` / `fail_addr` / `fail_wdata`  out  32/5/32  DUT fields of the first mismatch.

## Operation
- Event: `debug_wb_rf_wen && debug_wb_rf_addr != 0`. The event is pushed as {pc, addr, wdata}. All other cycles are ignored.
- FSM states: RUN (state after reset), PASS, FAIL. PASS and FAIL are terminal until reset.
- `ref_ready = (state == RUN) && fifo_not_empty`. This is combinational and must not depend on `ref_valid`.
- Compare fires when `ref_valid && ref_ready`. It pops the FIFO head and compares all three fields.
  - All fields equal: `match_count++`.
  - Any field differs: `err_count++` (saturates at all-ones). On the first mismatch only, capture `fail_*` from the FIFO head.
  - If `ref_last` is set on the compare: go to PASS if no error has occurred (including this compare); otherwise go to FAIL.
- Overflow: a push with the FIFO full and no pop in the same cycle. The event is dropped, `overflow` is set, and the FSM goes to FAIL. A push and a pop in the same cycle while full is legal and is not an overflow.
- In PASS/FAIL: no pushes, no pops, `ref_ready = 0`, and counters are frozen.
- `pass` = (state == PASS); `fail` = (state == FAIL). Both are registered.
- FIFO: circular buffer with log2(DEPTH)+1-bit read/write pointers that wrap modulo 2·DEPTH. Full/empty are derived from the MSB and the remaining bits.

## Timing
- All outputs reset to 0, including `fail_*`. The FIFO resets to empty. `resetn` low mid-run aborts immediately and clears everything.
- An event sampled at edge N is in the FIFO after N. `ref_ready` can first be high in cycle N+1. The earliest compare is at edge N+1.
- Counters, `fail_*`, and the state update at the compare edge and are visible the next cycle.
- A push and a pop in the same cycle leave the FIFO level unchanged.
- Overflow transitions to FAIL at the overflowing edge.
- Throughput: one compare per cycle.

## Configuration
- `TRACE_STOP_ON_ERR_EN` defined: the first mismatch moves the FSM to FAIL at that compare edge, and no further entries are consumed.
- Not defined: the checker stays in RUN after mismatches and keeps counting. The final verdict is decided at `ref_last`, or at an overflow.

## Test plan
- Five CPU events (r1..r5 ← 1..5, PCs 0x0..0x10), the golden stream identical, `ref_valid` always high, last entry flagged -> `match_count` = 5, `err_count` = 0, `pass` = 1 one cycle after the 5th compare.
- `debug_wb_rf_wen` = 1 with addr 0, plus bubble cycles (wen = 0) -> no FIFO push, `ref_ready` stays 0.
- Third entry with golden wdata 0x7 vs DUT 0x8, with `TRACE_STOP_ON_ERR_EN` -> `fail` = 1, `err_count` = 1, `fail_pc` = 0x8, `fail_wdata` = 0x8, `match_count` = 2. Without the macro -> checking continues, and `fail` = 1 at `ref_last`.
- `ref_valid` held low while DEPTH+1 = 9 events arrive -> `overflow` = 1 and `fail` = 1 on the 9th event edge. Raising `ref_valid` afterwards consumes nothing.
- FIFO full; then `ref_valid` = 1 with a new event in the same cycle -> no overflow, level stays at 8, pointers wrap correctly over 20 further events.
- `resetn` asserted low asynchronously mid-trace, between clock edges -> all outputs 0 immediately. After release, a fresh 3-entry trace passes.
